// File: rtl/bfp_mult_block_ctrl_if.sv
// Operand/product handshake bundle for the block-floating-point multiply controller.
// The master drives operands and downstream ready; the slave is the controller.
interface bfp_mult_block_ctrl_if #(
    parameter int FRAC_W = 11,
    parameter int EXP_W  = 5
);
    logic              start;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic              in_valid;
    logic              in_ready;
    logic [FRAC_W-1:0] a;
    logic [FRAC_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W-1:0] out_product;
    logic [EXP_W-1:0]  out_exp;
    logic              out_last;
    logic              ovf;
    logic              busy;

    modport master (
        output start, exp_a, exp_b, in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_product, out_exp, out_last, ovf, busy
    );

    modport slave (
        input  start, exp_a, exp_b, in_valid, a, b, out_ready,
        output in_ready, out_valid, out_product, out_exp, out_last, ovf, busy
    );
endinterface

// File: rtl/bfp_mult_block_ctrl.sv
// Buffers BLOCK_LEN full products, normalises them to one shared exponent, streams them out.
// First product 2 cycles after the last operand; output stalls hold under out_ready=0.
module bfp_mult_block_ctrl #(
    parameter int FRAC_W    = 11,
    parameter int EXP_W     = 5,
    parameter int BLOCK_LEN = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    bfp_mult_block_ctrl_if.slave bus
);
    localparam int P_W   = 2 * FRAC_W;
    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int SH_W  = $clog2(P_W);
    localparam int SUM_W = EXP_W + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, NORM, EMIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [P_W-1:0]    buffer [BLOCK_LEN];
    logic [P_W-1:0]    acc_or_q;
    logic [P_W-1:0]    prod;
    logic [P_W-1:0]    shifted;
    logic [EXP_W-1:0]  exp_a_q, exp_b_q, out_exp_q;
    logic [SH_W-1:0]   msb, shift_c, shift_q;
    logic [SUM_W-1:0]  sum;
    logic              ovf_q, in_fire, out_fire, sat;

    assign prod     = {{FRAC_W{1'b0}}, bus.a} * {{FRAC_W{1'b0}}, bus.b};
    assign in_fire  = (state_q == LOAD) && bus.in_valid;
    assign out_fire = (state_q == EMIT) && bus.out_ready;

    always_comb begin
        msb = '0;
        for (int i = 0; i < P_W; i++) begin
            if (acc_or_q[i]) msb = SH_W'(i);
        end
    end

    // Shift just far enough that the largest product in the block fits FRAC_W bits.
    assign shift_c = (msb >= SH_W'(FRAC_W)) ? msb - SH_W'(FRAC_W - 1) : '0;
    assign sum     = SUM_W'(exp_a_q) + SUM_W'(exp_b_q) + SUM_W'(shift_c);
    assign sat     = |sum[SUM_W-1:EXP_W];
    assign shifted = buffer[cnt_q] >> shift_q;

    assign bus.in_ready    = (state_q == LOAD);
    assign bus.out_valid   = (state_q == EMIT);
    assign bus.out_product = (state_q == EMIT) ? shifted[FRAC_W-1:0] : '0;
    assign bus.out_last    = (state_q == EMIT) && (cnt_q == LAST);
    assign bus.out_exp     = out_exp_q;
    assign bus.ovf         = ovf_q;
    assign bus.busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (in_fire && cnt_q == LAST) state_d = NORM;
            NORM:    state_d = EMIT;
            EMIT:    if (out_fire && cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_or_q  <= '0;
            exp_a_q   <= '0;
            exp_b_q   <= '0;
            shift_q   <= '0;
            out_exp_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.start) begin
                    exp_a_q   <= bus.exp_a;
                    exp_b_q   <= bus.exp_b;
                    cnt_q     <= '0;
                    acc_or_q  <= '0;
                    out_exp_q <= '0;
                    ovf_q     <= 1'b0;
                end
                LOAD: if (in_fire) begin
                    acc_or_q <= acc_or_q | prod;
                    cnt_q    <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
                NORM: begin
                    shift_q   <= shift_c;
                    out_exp_q <= sat ? {EXP_W{1'b1}} : sum[EXP_W-1:0];
                    ovf_q     <= sat;
                end
                EMIT: if (out_fire) begin
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Product storage needs no reset: every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (in_fire) buffer[cnt_q] <= prod;
    end
endmodule
